lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Initiator side of the core's EX data-memory port: a load/store unit converting execute-stage load/store requests into word-wide single-request bus transactions (addr, wdata, we, req, rdata).
- The bus has no byte strobes, so sub-word stores are done as read-modify-write; sub-word loads are lane-extracted and sign/zero-extended.
- Sits between the EX stage and the memory subsystem containing ITCM/DTCM.

Parameters:
- ADDR_WIDTH, 32, bus address width (`BUS_ADDR_WIDTH).
- DATA_WIDTH, 32, bus data width; only 32 supported.
- READ_LATENCY, 1, cycles from a read request to valid mem_rdata_i; legal values 0 or 1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- req_valid_i  input  1  EX request valid
- req_ready_o  output  1  LSU idle and able to accept
- req_we_i  input  1  1=store, 0=load
- req_size_i  input  2  LSU_SIZE_B/H/W
- req_unsigned_i  input  1  zero-extend load result
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wdata_i  input  DATA_WIDTH  store data, right-aligned
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  DATA_WIDTH  extended load data (0 for stores)
- resp_err_o  output  1  misaligned access, qualified by resp_valid_o
- mem_req_o  output  1  bus request
- mem_we_o  output  1  bus write enable
- mem_addr_o  output  ADDR_WIDTH  word-aligned bus address
- mem_wdata_o  output  DATA_WIDTH  bus write data
- mem_rdata_i  input  DATA_WIDTH  bus read data

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low.
- Reset values: all outputs 0; the state goes to IDLE. req_ready_o is 0 while rst=0.
- Accept: a request is accepted when req_valid_i && req_ready_o. req_ready_o = (state==IDLE). All request fields are registered on accept.
- States:
  - IDLE: waiting for a request.
  - RD: mem_req_o=1, mem_we_o=0.
  - RWAIT: entered only if READ_LATENCY=1. Captures mem_rdata_i.
  - WR: mem_req_o=1, mem_we_o=1.
  - RESP: resp_valid_o=1.
- mem_* outputs are registered. mem_addr_o = {addr[31:2],2'b00}. mem_req_o is high for exactly one cycle per bus access.
- Read data capture: in RWAIT when READ_LATENCY=1; in RD when READ_LATENCY=0 (RD then goes straight to the next state).
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Sequence is IDLE -> RESP with resp_err_o=1, resp_rdata_o=0, and no bus access.
- Load path (READ_LATENCY=1): accept T0, RD T1, RWAIT T2, RESP T3.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend unless req_unsigned_i.
- Word store: accept T0, WR T1 with mem_wdata_o=wdata, RESP T2.
- Sub-word store (RMW): RD T1, RWAIT T2, WR T3, RESP T4.
  - WR data is the captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Other bytes are unchanged.
- Response outputs:
  - resp_rdata_o/resp_err_o are held stable only during the resp_valid_o cycle and are 0 otherwise.
  - There is no response backpressure; EX must consume the pulse.
- RESP always returns to IDLE, so the next accept is at earliest the cycle after RESP.
- Reset mid-operation: the next edge forces IDLE and all outputs to 0. A pending RMW write is never issued and no response is generated.
- req_unsigned_i is ignored for words and stores.

Decomposition:
- Shared constants in defines.v:
  - LSU_SIZE_B=2'b00, LSU_SIZE_H=2'b01, LSU_SIZE_W=2'b10.
  - LSU state encodings.
  - NOP-free: no new bus typedefs.
- One combinational sub-module, lsu_lane_align:
  - load extract/extend: rdata, size, offset, unsigned -> result.
  - store merge: old word, wdata, size, offset -> new word.
  - Shared by both paths.

Test Plan:
- LW addr 0x00000104, mem_rdata_i=0xDEADBEEF at T2:
  - mem_req_o=1/we=0/addr=0x104 at T1.
  - resp_valid_o at T3 with rdata 0xDEADBEEF, err 0.
- LB addr 0x107, read word 0x80FF0000:
  - resp_rdata_o=0xFFFFFF80.
  - Same request with req_unsigned_i=1 -> 0x00000080.
  - LH addr 0x106 -> 0xFFFF80FF.
- SB addr 0x105, wdata 0x000000AB, read word 0x11223344:
  - Exactly one read at T1 (addr 0x104).
  - Write at T3 with mem_wdata_o=0x1122AB44, we=1.
  - resp at T4.
- LW addr 0x102 and SH addr 0x101:
  - resp_valid_o at T1 with err=1.
  - mem_req_o never asserted.
- SH addr 0x100 with rst driven low during RWAIT:
  - mem_req_o/we stay 0 (no write), resp_valid_o never pulses.
  - req_ready_o=0 during reset, 1 the cycle after rst returns high.
- Back-to-back: req_valid_i held high with two LWs:
  - Second is accepted only in the IDLE cycle after the first RESP.
  - req_ready_o=0 T1–T3; READ_LATENCY=0 build completes an LW with RESP at T2.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// Shared constants for the LSU bus master: access sizes, FSM encodings and
// the alignment rule used by both the accept path and anything that needs it.
package lsu_bus_master_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_RD    = 3'd1,
    LSU_RWAIT = 3'd2,
    LSU_WR    = 3'd3,
    LSU_RESP  = 3'd4
  } lsu_state_e;

  // Bytes are always aligned; any size code above half is treated as a word.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (size == LSU_SIZE_H)      mis = off[0];
    else if (size != LSU_SIZE_B) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_bus_master_lane_align.sv
// Byte/half lane steering shared by the load and store paths: extracts and
// extends a load result, and merges store data into a previously read word.
module lsu_lane_align
  import lsu_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32
)(
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_size,
  input  logic [1:0]            i_off,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic [DATA_WIDTH-1:0] o_st_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ld_data = i_rdata;
    w_sign    = 1'b0;
    case (i_size)
      LSU_SIZE_B: begin
        w_sign    = ~i_unsigned & w_byte[7];
        o_ld_data = {{24{w_sign}}, w_byte};
      end
      LSU_SIZE_H: begin
        w_sign    = ~i_unsigned & w_half[15];
        o_ld_data = {{16{w_sign}}, w_half};
      end
      default: o_ld_data = i_rdata;
    endcase
  end

  // Untouched lanes keep the bytes read back from memory.
  always_comb begin
    o_st_data = i_rdata;
    case (i_size)
      LSU_SIZE_B: o_st_data[{i_off, 3'b000} +: 8]       = i_wdata[7:0];
      LSU_SIZE_H: o_st_data[{i_off[1], 4'b0000} +: 16]  = i_wdata[15:0];
      default:    o_st_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// EX-stage load/store unit driving a word-wide, strobe-less data bus.
// Sub-word stores are read-modify-write; all bus and response outputs are registered.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            r_state;
  lsu_state_e            w_next;

  logic                  r_we;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_req_err;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [DATA_WIDTH-1:0] w_st_data;

  logic                  w_mem_req_d;
  logic                  w_mem_we_d;
  logic [ADDR_WIDTH-1:0] w_mem_addr_d;
  logic [DATA_WIDTH-1:0] w_mem_wdata_d;
  logic                  w_resp_valid_d;
  logic [DATA_WIDTH-1:0] w_resp_rdata_d;
  logic                  w_resp_err_d;

  assign req_ready_o = rst && (r_state == LSU_IDLE);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_req_err   = lsu_misaligned(req_size_i, req_addr_i[1:0]);

  // The cycle in which mem_rdata_i holds the word for the outstanding read.
  assign w_capture   = (READ_LATENCY == 0) ? (r_state == LSU_RD)
                                           : (r_state == LSU_RWAIT);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= LSU_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= LSU_SIZE_B;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= req_we_i;
      r_unsigned <= req_unsigned_i;
      r_size     <= req_size_i;
      r_addr     <= req_addr_i;
      r_wdata    <= req_wdata_i;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                     w_next = LSU_RESP;
          else if (!req_we_i)                w_next = LSU_RD;
          else if (req_size_i == LSU_SIZE_W) w_next = LSU_WR;
          else                               w_next = LSU_RD;
        end
      end
      LSU_RD: begin
        if (READ_LATENCY != 0) w_next = LSU_RWAIT;
        else                   w_next = r_we ? LSU_WR : LSU_RESP;
      end
      LSU_RWAIT: w_next = r_we ? LSU_WR : LSU_RESP;
      LSU_WR:    w_next = LSU_RESP;
      LSU_RESP:  w_next = LSU_IDLE;
      default:   w_next = LSU_IDLE;
    endcase
  end

  // Next values for the registered outputs, keyed on the state being entered.
  always_comb begin
    w_mem_req_d    = (w_next == LSU_RD) || (w_next == LSU_WR);
    w_mem_we_d     = (w_next == LSU_WR);
    w_mem_addr_d   = '0;
    w_mem_wdata_d  = '0;
    w_resp_valid_d = (w_next == LSU_RESP);
    w_resp_rdata_d = '0;
    w_resp_err_d   = 1'b0;

    if (w_mem_req_d) begin
      if (r_state == LSU_IDLE) w_mem_addr_d = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
      else                     w_mem_addr_d = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    end

    if (w_mem_we_d) begin
      if (r_state == LSU_IDLE) w_mem_wdata_d = req_wdata_i;
      else                     w_mem_wdata_d = w_st_data;
    end

    if (w_resp_valid_d) begin
      if (r_state == LSU_IDLE)           w_resp_err_d   = w_req_err;
      else if (w_capture && !r_we)       w_resp_rdata_d = w_ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      mem_req_o    <= w_mem_req_d;
      mem_we_o     <= w_mem_we_d;
      mem_addr_o   <= w_mem_addr_d;
      mem_wdata_o  <= w_mem_wdata_d;
      resp_valid_o <= w_resp_valid_d;
      resp_rdata_o <= w_resp_rdata_d;
      resp_err_o   <= w_resp_err_d;
    end
  end

  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .i_rdata    (mem_rdata_i),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_off      (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .o_ld_data  (w_ld_data),
    .o_st_data  (w_st_data)
  );

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: transaction-level model predicts every output
// cycle by cycle; a small word memory acts as the bus slave.
module tb_lsu_bus_master;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  lsu_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rv;
    logic [31:0] rd;
    bit          err;
    bit          rdy;
    bit          commit;
    int          cidx;
    logic [31:0] cval;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          cur_ready = 1'b0;
  logic [31:0] smem [8];
  logic [31:0] rmem [8];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          set_seq = 0, set_done = 0, set_idx = 0;
  logic [31:0] set_val = '0;
  int          last_resp_cyc = 0, last_wr_cyc = 0;
  int          n_rd = 0, n_wr = 0, n_resp = 0;
  logic [31:0] last_resp_rd = '0, last_wr_data = '0;
  logic        last_resp_err = 1'b0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_pend_addr = '0;

  function automatic exp_t mk(bit rq, bit we, logic [31:0] a, logic [31:0] wd,
                              bit rv, logic [31:0] rd, bit err);
    exp_t e;
    e.req = rq; e.we = we; e.addr = a; e.wdata = wd;
    e.rv = rv; e.rd = rd; e.err = err; e.rdy = 1'b0;
    e.commit = 1'b0; e.cidx = 0; e.cval = '0;
    return e;
  endfunction

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] sz,
                                         logic [1:0] off, bit uns);
    logic [31:0] v;
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v &= 32'h0000_00FF;
      if (!uns && v[7]) v |= 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v &= 32'h0000_FFFF;
      if (!uns && v[15]) v |= 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd,
                                        logic [1:0] sz, logic [1:0] off);
    logic [31:0] mask;
    mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // Expected outputs for every cycle after the accept edge.
  task automatic model_push(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
    int          idx;
    logic [31:0] wa;
    logic [1:0]  off;
    logic [31:0] old;
    exp_t        e;
    idx = int'(a[4:2]);
    wa  = {a[31:2], 2'b00};
    off = a[1:0];
    old = rmem[idx];
    if ((sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0)) begin
      exp_q.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b1));
    end else begin
      if (!(we && sz == 2'd2)) begin
        exp_q.push_back(mk(1'b1, 1'b0, wa, '0, 1'b0, '0, 1'b0));
        if (LAT == 1) exp_q.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0));
      end
      if (we) begin
        e = mk(1'b1, 1'b1, wa, (sz == 2'd2) ? wd : merge(old, wd, sz, off), 1'b0, '0, 1'b0);
        e.commit = 1'b1; e.cidx = idx; e.cval = e.wdata;
        exp_q.push_back(e);
      end
      exp_q.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, we ? 32'h0 : ld_ext(old, sz, off, uns), 1'b0));
    end
  endtask

  // Compare, model bookkeeping and bus slave, 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (set_seq != set_done) begin
      smem[set_idx] = set_val;
      rmem[set_idx] = set_val;
      set_done = set_seq;
    end
    if (!rst) begin
      exp_q.delete();
      cur = mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      cur.rdy = 1'b1;
    end
    checks++;
    if (mem_req_o !== cur.req || mem_we_o !== cur.we || mem_addr_o !== cur.addr ||
        mem_wdata_o !== cur.wdata || resp_valid_o !== cur.rv || resp_rdata_o !== cur.rd ||
        resp_err_o !== cur.err || req_ready_o !== cur.rdy) begin
      errors++;
      $display("FAIL cycle_%0d outputs: got req=%b we=%b addr=%h wdata=%h rv=%b rd=%h err=%b rdy=%b, expected req=%b we=%b addr=%h wdata=%h rv=%b rd=%h err=%b rdy=%b",
               cyc, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, resp_valid_o, resp_rdata_o,
               resp_err_o, req_ready_o, cur.req, cur.we, cur.addr, cur.wdata, cur.rv, cur.rd,
               cur.err, cur.rdy);
    end
    if (cur.commit) rmem[cur.cidx] = cur.cval;
    cur_ready = cur.rdy;
    if (resp_valid_o === 1'b1) begin
      last_resp_cyc = cyc; last_resp_rd = resp_rdata_o; last_resp_err = resp_err_o; n_resp++;
    end
    if (mem_req_o === 1'b1 && mem_we_o === 1'b1) begin
      smem[mem_addr_o[4:2]] = mem_wdata_o;
      last_wr_cyc = cyc; last_wr_data = mem_wdata_o; n_wr++;
    end
    if (mem_req_o === 1'b1 && mem_we_o === 1'b0) n_rd++;
    if (LAT == 0)
      mem_rdata_i = (mem_req_o === 1'b1 && mem_we_o === 1'b0) ? smem[mem_addr_o[4:2]] : $urandom;
    else
      mem_rdata_i = rd_pend ? smem[rd_pend_addr[4:2]] : $urandom;
    rd_pend      = (mem_req_o === 1'b1 && mem_we_o === 1'b0);
    rd_pend_addr = mem_addr_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic set_word(int idx, logic [31:0] v);
    set_idx = idx;
    set_val = v;
    set_seq++;
    tick();
  endtask

  task automatic noise();
    req_we_i       = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
    req_addr_i     = $urandom;
    req_wdata_i    = $urandom;
  endtask

  task automatic issue(bit we, logic [1:0] sz, bit uns, logic [31:0] a,
                       logic [31:0] wd, bit hold, output int acc);
    int n;
    n = 0;
    while (!cur_ready && n < 40) begin tick(); n++; end
    if (!cur_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got ready=0 expected ready=1 within 40 cycles");
      req_valid_i = 1'b0;
      acc = -1;
      return;
    end
    req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd; req_valid_i = 1'b1;
    acc = cyc;
    model_push(we, sz, uns, a, wd);
    tick();
    if (!hold) begin req_valid_i = 1'b0; noise(); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cur_ready && n < 40) begin tick(); n++; end
    if (!cur_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle within 40 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc2, r0, w0, q0;
    repeat (3) tick();
    chk("reset_ready", 32'(req_ready_o), 32'h0);
    chk("reset_req", 32'(mem_req_o), 32'h0);
    chk("reset_resp", 32'(resp_valid_o), 32'h0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) set_word(i, $urandom);

    // Plain word load
    set_word(1, 32'hDEAD_BEEF);
    r0 = n_rd;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0104, '0, 1'b0, acc);
    wait_idle();
    chk("lw_data", last_resp_rd, 32'hDEAD_BEEF);
    chk("lw_latency", 32'(last_resp_cyc - acc), 32'(2 + LAT));
    chk("lw_reads", 32'(n_rd - r0), 32'd1);

    // Sub-word loads with sign/zero extension
    set_word(1, 32'h80FF_0000);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0107, '0, 1'b0, acc);
    wait_idle();
    chk("lb_signed", last_resp_rd, 32'hFFFF_FF80);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0107, '0, 1'b0, acc);
    wait_idle();
    chk("lbu", last_resp_rd, 32'h0000_0080);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0106, '0, 1'b0, acc);
    wait_idle();
    chk("lh_signed", last_resp_rd, 32'hFFFF_80FF);

    // Byte store via read-modify-write
    set_word(1, 32'h1122_3344);
    r0 = n_rd;
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0105, 32'h0000_00AB, 1'b0, acc);
    wait_idle();
    chk("sb_wdata", last_wr_data, 32'h1122_AB44);
    chk("sb_wr_cycle", 32'(last_wr_cyc - acc), 32'(2 + LAT));
    chk("sb_resp_cycle", 32'(last_resp_cyc - acc), 32'(3 + LAT));
    chk("sb_reads", 32'(n_rd - r0), 32'd1);

    // Misaligned accesses answer immediately with no bus traffic
    q0 = n_rd + n_wr;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0102, '0, 1'b0, acc);
    wait_idle();
    chk("lw_mis_err", 32'(last_resp_err), 32'h1);
    chk("lw_mis_cycle", 32'(last_resp_cyc - acc), 32'd1);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_5555, 1'b0, acc);
    wait_idle();
    chk("sh_mis_err", 32'(last_resp_err), 32'h1);
    chk("sh_mis_cycle", 32'(last_resp_cyc - acc), 32'd1);
    chk("mis_no_bus", 32'(n_rd + n_wr - q0), 32'd0);

    // Reset while the half store waits for its read data
    set_word(0, 32'hCAFE_F00D);
    w0 = n_wr;
    r0 = n_resp;
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0100, 32'h0000_1234, 1'b0, acc);
    if (LAT == 1) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready_low", 32'(req_ready_o), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_ready_back", 32'(req_ready_o), 32'h1);
    chk("rst_no_write", 32'(n_wr - w0), 32'd0);
    chk("rst_no_resp", 32'(n_resp - r0), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, '0, 1'b0, acc);
    wait_idle();
    chk("rst_mem_intact", last_resp_rd, 32'hCAFE_F00D);

    // Back-to-back loads with valid held high
    set_word(2, 32'h1357_9BDF);
    set_word(3, 32'h0BAD_C0DE);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0108, '0, 1'b1, acc);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_010C, '0, 1'b0, acc2);
    wait_idle();
    chk("b2b_spacing", 32'(acc2 - acc), 32'(3 + LAT));
    chk("b2b_data", last_resp_rd, 32'h0BAD_C0DE);

    // Random traffic over a small window of words
    for (int i = 0; i < 300; i++) begin
      bit hold;
      hold = (i != 299) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
            32'h0000_0100 + 32'($urandom_range(0, 31)), $urandom, hold, acc);
      if (!hold) repeat ($urandom_range(0, 2)) tick();
    end
    req_valid_i = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
